tdm_demux_1_4: RTL and testbench
================================

// Module: tdm_demux_1_4
// PURPOSE
//  Receive-side partner of the 4:1 lane mux. A single time-division-multiplexed sample
//  stream (lane 0,1,2,3,0,...) is split back into 4 lanes. Samples are collected per
//  frame and presented as one 4-lane word on a valid/ready output.
//  Locks on an in-band start-of-frame marker and recovers from misaligned frames.
// PARAMETERS
//  WIDTH   4   bits per lane sample; out_data is 4*WIDTH
// PORTS
//  clk        in   1        rising-edge clock
//  reset      in   1        asynchronous, active-high reset
//  in_valid   in   1        in_data/in_sof valid this cycle
//  in_ready   out  1        block accepts sample (accept = in_valid & in_ready)
//  in_data    in   WIDTH    TDM sample
//  in_sof     in   1        sample is lane 0 of a frame
//  out_valid  out  1        out_data holds a complete frame
//  out_ready  in   1        consumer takes frame (transfer = out_valid & out_ready)
//  out_data   out  4*WIDTH  lane k at bits [k*WIDTH +: WIDTH]; lane 0 in LSBs
//  slot       out  2        lane index the next accepted sample is written to
//  locked     out  1        1 in ASSEMBLE state
//  sof_err    out  1        1-cycle pulse: sof seen at slot != 0
// BEHAVIOUR
//  Reset (async, any time, mid-frame included): state=HUNT, slot=0, asm regs=0,
//   out_data=0, out_valid=0, locked=0, sof_err=0. Any partial or held frame is lost.
//  FSM HUNT: in_ready=1; accepted samples with in_sof=0 are dropped. Accepted sample
//   with in_sof=1 -> asm[0]=in_data, slot=1, go to ASSEMBLE.
//  FSM ASSEMBLE: accepted sample written to asm[slot]; slot increments mod 4 (3->0).
//   - Frame complete: accept at slot==3. Next edge: out_data={in_data,asm[2],asm[1],asm[0]},
//     out_valid=1. Latency: lane-3 accept edge -> out_valid high 1 cycle later.
//   - in_sof=1 at slot==0: normal, no error.
//   - in_sof=1 at slot!=0 (resync): partial frame dropped, asm[0]=in_data, slot=1,
//     sof_err=1 for exactly one cycle. State stays ASSEMBLE. No frame output.
//   - in_sof=1 and slot==3 together: resync rule wins, no frame output.
//  Output handshake: out_valid stays 1 and out_data stays stable until transfer.
//   Transfer with no new frame completing the same edge -> out_valid=0.
//   Transfer and a frame completing the same edge -> new frame loaded, out_valid stays 1.
//  Backpressure: in_ready = ~(locked & slot==3 & out_valid & ~out_ready). Applies
//   combinationally, including out_ready dropping in the same cycle. Frames are never
//   overwritten or lost. Slots 0..2 keep being accepted while a frame is held.
//  sof_err defaults 0. It is registered and is high only the cycle after the offending
//   accept.
//  No accept (in_valid=0 or in_ready=0): slot, asm, state unchanged.
// TESTING (WIDTH=4)
//  1 Reset release, out_ready=1, stream sof=1 on 0x1, then 0x2,0x3,0x4 back-to-back
//    -> out_valid 1 cycle after 0x4 accept, out_data=16'h4321, locked=1, slot wraps to 0.
//  2 After reset, send 0xA,0xB (sof=0) and then sof on 0x1,0x2,0x3,0x4
//    -> 0xA/0xB dropped, single frame 16'h4321, sof_err never pulses.
//  3 Locked, send sof 0x5, 0x6, then sof 0x7,0x8,0x9,0xA
//    -> sof_err one-cycle pulse on the 2nd sof, only frame output = 16'hA987.
//  4 Hold out_ready=0 and stream 2 frames 0x1..0x4, 0x5..0x8
//    -> first frame 16'h4321 held; in_ready=0 at slot 3 with 0x8 pending.
//    Raise out_ready: 16'h4321 transfers, 0x8 accepted, next frame 16'h8765.
//  5 Continuous frames with out_ready=1 every cycle -> one frame per 4 accepts,
//    out_valid stays high across back-to-back frames, no samples lost.
//  6 Assert reset mid-frame (after 0x1,0x2) and while a frame is held
//    -> all outputs 0 immediately (async), HUNT. Next frame needs a fresh sof.

Source files
------------

// File: rtl/tdm_demux_1_4.sv
// ---------------------------------------------------------------------------
// tdm_demux_1_4
// Receive-side partner of the 4:1 lane mux. Splits a TDM sample stream
// (lane 0,1,2,3,0,...) back into 4 lanes. It locks on the in-band
// start-of-frame marker and presents each complete frame as one 4-lane word
// on a valid/ready output.
//
// Ports
//   clk        in   1        rising-edge clock
//   reset      in   1        asynchronous, active-high reset
//   in_valid   in   1        in_data/in_sof valid this cycle
//   in_ready   out  1        sample accepted when in_valid & in_ready (combinational)
//   in_data    in   WIDTH    TDM sample
//   in_sof     in   1        sample is lane 0 of a frame
//   out_valid  out  1        out_data holds a complete frame
//   out_ready  in   1        consumer takes frame when out_valid & out_ready
//   out_data   out  4*WIDTH  lane k at [k*WIDTH +: WIDTH], lane 0 in LSBs
//   slot       out  2        lane index of the next accepted sample
//   locked     out  1        high while assembling frames (locked to sof)
//   sof_err    out  1        one-cycle pulse: sof seen at slot != 0
// ---------------------------------------------------------------------------
module tdm_demux_1_4 #(
  parameter int unsigned WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_data,
  input  logic                 in_sof,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [4*WIDTH-1:0]   out_data,
  output logic [1:0]           slot,
  output logic                 locked,
  output logic                 sof_err
);

  localparam int unsigned OUT_W = 4 * WIDTH;

  localparam logic ST_HUNT     = 1'b0;
  localparam logic ST_ASSEMBLE = 1'b1;

  logic              state_q,     state_d;
  logic [1:0]        slot_q,      slot_d;
  logic [WIDTH-1:0]  asm_q [3];
  logic [WIDTH-1:0]  asm_d [3];
  logic [OUT_W-1:0]  out_data_q,  out_data_d;
  logic              out_valid_q, out_valid_d;
  logic              sof_err_q,   sof_err_d;
  logic              accept;

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign slot      = slot_q;
  assign locked    = (state_q == ST_ASSEMBLE);
  assign sof_err   = sof_err_q;

  // Stall only the lane-3 sample: it would complete a frame with nowhere to go.
  always_comb begin
    in_ready = ~(locked & (slot_q == 2'd3) & out_valid_q & ~out_ready);
  end

  assign accept = in_valid & in_ready;

  // Next-state: lock/resync, lane assembly and output handshake.
  always_comb begin
    state_d     = state_q;
    slot_d      = slot_q;
    asm_d       = asm_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    sof_err_d   = 1'b0;

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    if (accept) begin
      case (state_q)
        ST_HUNT: begin
          if (in_sof) begin
            asm_d[0] = in_data;
            slot_d   = 2'd1;
            state_d  = ST_ASSEMBLE;
          end
        end
        ST_ASSEMBLE: begin
          if (in_sof && (slot_q != 2'd0)) begin
            // Misaligned sof: restart the frame on this sample.
            asm_d[0]  = in_data;
            slot_d    = 2'd1;
            sof_err_d = 1'b1;
          end else if (slot_q == 2'd3) begin
            out_data_d  = {in_data, asm_q[2], asm_q[1], asm_q[0]};
            out_valid_d = 1'b1;
            slot_d      = 2'd0;
          end else begin
            for (int k = 0; k < 3; k++) begin
              if (slot_q == 2'(k)) begin
                asm_d[k] = in_data;
              end
            end
            slot_d = slot_q + 2'd1;
          end
        end
        default: begin
          state_d = ST_HUNT;
          slot_d  = 2'd0;
        end
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_HUNT;
      slot_q      <= 2'd0;
      asm_q       <= '{default: '0};
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      sof_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      slot_q      <= slot_d;
      asm_q       <= asm_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      sof_err_q   <= sof_err_d;
    end
  end

endmodule

// File: tb/tb_tdm_demux_1_4.sv
// ---------------------------------------------------------------------------
// tb_tdm_demux_1_4
// Scoreboard bench: each test pushes the frames it expects, a negedge monitor
// pops and compares every output transfer, and tests check flags inline.
// ---------------------------------------------------------------------------
module tb_tdm_demux_1_4;

  localparam int unsigned WIDTH = 4;

  logic              clk;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [WIDTH-1:0]  in_data;
  logic              in_sof;
  logic              out_valid;
  logic              out_ready;
  logic [4*WIDTH-1:0] out_data;
  logic [1:0]        slot;
  logic              locked;
  logic              sof_err;

  int total;
  int passed;
  int sof_err_cnt;
  logic [15:0] exp_q [$];

  tdm_demux_1_4 #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sof    (in_sof),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .slot      (slot),
    .locked    (locked),
    .sof_err   (sof_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output monitor: a transfer happens on the next posedge when both are high.
  always @(negedge clk) begin
    if (!reset) begin
      if (sof_err) sof_err_cnt++;
      if (out_valid && out_ready) begin
        total++;
        if (exp_q.size() == 0) begin
          $display("FAIL frame_unexpected got %h exp none", out_data);
        end else begin
          if (out_data !== exp_q[0])
            $display("FAIL frame_out got %h exp %h", out_data, exp_q[0]);
          else
            passed++;
          void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic send(input logic [3:0] d, input logic sof);
    int n;
    in_valid = 1'b1;
    in_data  = d;
    in_sof   = sof;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) begin
      total++;
      $display("FAIL send_timeout got in_ready=%b exp 1", in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    in_valid = 1'b0;
    in_sof   = 1'b0;
    in_data  = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(posedge clk);
      n++;
    end
    #1;
    total++;
    if (exp_q.size() != 0)
      $display("FAIL drain got %0d pending exp 0", exp_q.size());
    else
      passed++;
  endtask

  task automatic test_reset();
    out_ready = 1'b1;
    do_reset();
    total++;
    if ({out_valid, locked, slot, sof_err, in_ready} !== 6'b0_0_00_0_1)
      $display("FAIL reset_flags got %b exp 000001", {out_valid, locked, slot, sof_err, in_ready});
    else passed++;
    total++;
    if (out_data !== 16'h0000) $display("FAIL reset_data got %h exp 0000", out_data);
    else passed++;
  endtask

  task automatic test_basic_frame();
    exp_q.push_back(16'h4321);
    send(4'h1, 1'b1);
    send(4'h2, 1'b0);
    send(4'h3, 1'b0);
    total++;
    if (slot !== 2'd3 || locked !== 1'b1) $display("FAIL basic_slot3 got slot=%0d locked=%b exp 3 1", slot, locked);
    else passed++;
    send(4'h4, 1'b0);
    total++;
    if (out_valid !== 1'b1 || out_data !== 16'h4321)
      $display("FAIL basic_latency got v=%b d=%h exp 1 4321", out_valid, out_data);
    else passed++;
    total++;
    if (slot !== 2'd0 || locked !== 1'b1) $display("FAIL basic_wrap got slot=%0d locked=%b exp 0 1", slot, locked);
    else passed++;
    drain();
  endtask

  task automatic test_hunt_drop();
    int e0;
    do_reset();
    e0 = sof_err_cnt;
    send(4'hA, 1'b0);
    send(4'hB, 1'b0);
    total++;
    if (locked !== 1'b0 || slot !== 2'd0) $display("FAIL hunt_drop got locked=%b slot=%0d exp 0 0", locked, slot);
    else passed++;
    exp_q.push_back(16'h4321);
    send(4'h1, 1'b1);
    send(4'h2, 1'b0);
    send(4'h3, 1'b0);
    send(4'h4, 1'b0);
    drain();
    total++;
    if (sof_err_cnt - e0 != 0) $display("FAIL hunt_sof_err got %0d exp 0", sof_err_cnt - e0);
    else passed++;
  endtask

  task automatic test_resync();
    int e0;
    e0 = sof_err_cnt;
    exp_q.push_back(16'hA987);
    send(4'h5, 1'b1);
    send(4'h6, 1'b0);
    send(4'h7, 1'b1);
    total++;
    if (sof_err !== 1'b1 || slot !== 2'd1) $display("FAIL resync_pulse got err=%b slot=%0d exp 1 1", sof_err, slot);
    else passed++;
    send(4'h8, 1'b0);
    total++;
    if (sof_err !== 1'b0) $display("FAIL resync_one_cycle got %b exp 0", sof_err);
    else passed++;
    send(4'h9, 1'b0);
    send(4'hA, 1'b0);
    drain();
    total++;
    if (sof_err_cnt - e0 != 1) $display("FAIL resync_count got %0d exp 1", sof_err_cnt - e0);
    else passed++;
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    exp_q.push_back(16'h4321);
    exp_q.push_back(16'h8765);
    send(4'h1, 1'b1);
    send(4'h2, 1'b0);
    send(4'h3, 1'b0);
    send(4'h4, 1'b0);
    send(4'h5, 1'b1);
    send(4'h6, 1'b0);
    send(4'h7, 1'b0);
    in_valid = 1'b1;
    in_data  = 4'h8;
    in_sof   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (in_ready !== 1'b0 || slot !== 2'd3) $display("FAIL bp_stall got rdy=%b slot=%0d exp 0 3", in_ready, slot);
    else passed++;
    total++;
    if (out_valid !== 1'b1 || out_data !== 16'h4321) $display("FAIL bp_hold got v=%b d=%h exp 1 4321", out_valid, out_data);
    else passed++;
    out_ready = 1'b1;
    #1;
    total++;
    if (in_ready !== 1'b1) $display("FAIL bp_release got %b exp 1", in_ready);
    else passed++;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    total++;
    if (out_valid !== 1'b1 || out_data !== 16'h8765 || slot !== 2'd0)
      $display("FAIL bp_reload got v=%b d=%h slot=%0d exp 1 8765 0", out_valid, out_data, slot);
    else passed++;
    drain();
  endtask

  task automatic test_back_to_back();
    int e0;
    logic [15:0] f;
    logic [3:0]  d;
    e0 = sof_err_cnt;
    out_ready = 1'b1;
    for (int fr = 0; fr < 3; fr++) begin
      f = '0;
      for (int l = 0; l < 4; l++) begin
        d = 4'($urandom_range(0, 15));
        f[l*4 +: 4] = d;
      end
      exp_q.push_back(f);
      for (int l = 0; l < 4; l++) send(f[l*4 +: 4], l == 0);
      total++;
      if (out_valid !== 1'b1) $display("FAIL b2b_valid frame %0d got %b exp 1", fr, out_valid);
      else passed++;
    end
    drain();
    total++;
    if (sof_err_cnt - e0 != 0) $display("FAIL b2b_sof_err got %0d exp 0", sof_err_cnt - e0);
    else passed++;
  endtask

  task automatic test_async_reset();
    send(4'h1, 1'b1);
    send(4'h2, 1'b0);
    #2 reset = 1'b1;
    #1;
    total++;
    if ({out_valid, locked, slot, sof_err} !== 5'b0) $display("FAIL areset_mid got %b exp 00000", {out_valid, locked, slot, sof_err});
    else passed++;
    @(posedge clk);
    @(negedge clk) reset = 1'b0;
    send(4'h3, 1'b0);
    send(4'h4, 1'b0);
    total++;
    if (locked !== 1'b0 || slot !== 2'd0) $display("FAIL areset_needs_sof got locked=%b slot=%0d exp 0 0", locked, slot);
    else passed++;
    out_ready = 1'b0;
    send(4'h1, 1'b1);
    send(4'h2, 1'b0);
    send(4'h3, 1'b0);
    send(4'h4, 1'b0);
    total++;
    if (out_valid !== 1'b1) $display("FAIL areset_held_pre got %b exp 1", out_valid);
    else passed++;
    #2 reset = 1'b1;
    #1;
    total++;
    if (out_valid !== 1'b0 || out_data !== 16'h0 || locked !== 1'b0)
      $display("FAIL areset_held got v=%b d=%h l=%b exp 0 0000 0", out_valid, out_data, locked);
    else passed++;
    @(posedge clk);
    @(negedge clk) reset = 1'b0;
    out_ready = 1'b1;
    exp_q.push_back(16'h8765);
    send(4'h5, 1'b1);
    send(4'h6, 1'b0);
    send(4'h7, 1'b0);
    send(4'h8, 1'b0);
    drain();
  endtask

  initial begin
    total = 0;
    passed = 0;
    sof_err_cnt = 0;
    reset = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    in_sof = 1'b0;
    out_ready = 1'b1;
    test_reset();
    test_basic_frame();
    test_hunt_drop();
    test_resync();
    test_backpressure();
    test_back_to_back();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
